// File: rtl/branch_ctrl_unit.sv
// Branch control: flag register, branch condition evaluation, next-address select, flush/halt sequencing.
// Optional macro BRANCH_FLAG_BYPASS_EN: evaluate conditions on same-cycle ALU flags when flags_we=1.
module branch_ctrl_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_valid,
    input  logic [3:0]       branch_op,
    input  logic             flags_we,
    input  logic             alu_zero,
    input  logic             alu_sign,
    input  logic             alu_carry,
    input  logic             resume,
    output logic [1:0]       branch_control_out,
    output logic             flush,
    output logic             pc_stall,
    output logic [2:0]       flags_q,
    output logic [CNT_W-1:0] taken_cnt
);

    typedef enum logic [1:0] {S_RUN, S_FLUSH, S_HALT} state_t;

    localparam logic [1:0] SEL_PC_ADD = 2'b00;
    localparam logic [1:0] SEL_INSTR  = 2'b01;
    localparam logic [1:0] SEL_REG    = 2'b10;

    state_t           state_q, state_d;
    logic             flush_q;
    logic [2:0]       flags_d;
    logic [2:0]       ev_flags;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             taken, is_jr, halt_op;

`ifdef BRANCH_FLAG_BYPASS_EN
    assign ev_flags = flags_we ? {alu_carry, alu_sign, alu_zero} : flags_q;
`else
    assign ev_flags = flags_q;
`endif

    assign flags_d = flags_we ? {alu_carry, alu_sign, alu_zero} : flags_q;

    // Decisions are suppressed while reset is asserted so the mux select reads 00.
    always_comb begin
        taken   = 1'b0;
        is_jr   = 1'b0;
        halt_op = 1'b0;
        if (rst_n && state_q == S_RUN && instr_valid) begin
            case (branch_op)
                4'd1:    taken = 1'b1;
                4'd2:    taken = ev_flags[1];
                4'd3:    taken = ~ev_flags[1];
                4'd4:    taken = ev_flags[0];
                4'd5:    taken = ~ev_flags[0];
                4'd6:    taken = ev_flags[2];
                4'd7:    taken = ~ev_flags[2];
                4'd8:    begin taken = 1'b1; is_jr = 1'b1; end
                4'd9:    halt_op = 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d            = state_q;
        branch_control_out = SEL_PC_ADD;
        cnt_d              = cnt_q;
        case (state_q)
            S_RUN: begin
                if (taken) begin
                    branch_control_out = is_jr ? SEL_REG : SEL_INSTR;
                    state_d            = S_FLUSH;
                    if (cnt_q != {CNT_W{1'b1}})
                        cnt_d = cnt_q + 1'b1;
                end else if (halt_op) begin
                    state_d = S_HALT;
                end
            end
            S_FLUSH: state_d = S_RUN;
            S_HALT:  if (resume) state_d = S_RUN;
            default: state_d = S_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_RUN;
            flush_q <= 1'b0;
            flags_q <= 3'b000;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            flush_q <= (state_d == S_FLUSH);
            flags_q <= flags_d;
            cnt_q   <= cnt_d;
        end
    end

    assign flush     = flush_q;
    assign pc_stall  = rst_n && (state_q == S_HALT || halt_op);
    assign taken_cnt = cnt_q;

endmodule

// File: tb/tb_branch_ctrl_unit.sv
// Bench for branch_ctrl_unit: directed literal checks plus randomized run against a behavioural model.
module tb_branch_ctrl_unit;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n, instr_valid, flags_we, alu_zero, alu_sign, alu_carry, resume;
    logic [3:0]       branch_op;
    logic [1:0]       branch_control_out;
    logic             flush, pc_stall;
    logic [2:0]       flags_q;
    logic [CNT_W-1:0] taken_cnt;

    int checks = 0;
    int passes = 0;

    branch_ctrl_unit #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .branch_op(branch_op),
        .flags_we(flags_we), .alu_zero(alu_zero), .alu_sign(alu_sign), .alu_carry(alu_carry),
        .resume(resume), .branch_control_out(branch_control_out), .flush(flush),
        .pc_stall(pc_stall), .flags_q(flags_q), .taken_cnt(taken_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic drv(input logic v, input logic [3:0] op, input logic we,
                       input logic [2:0] csz, input logic res, input logic rn);
        instr_valid = v; branch_op = op; flags_we = we;
        {alu_carry, alu_sign, alu_zero} = csz; resume = res; rst_n = rn;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Behavioural model: flag bits, running/flushing/halted status, counter as an int.
    logic [2:0] m_flags = 3'b000;
    bit         m_fl = 1'b0, m_halt = 1'b0;
    int         m_cnt = 0;
    bit         model_on = 1'b0;

    always @(negedge clk) begin
        if (model_on) begin
            logic [2:0] f;
            bit run, tk, jr, hop;
            int esel;
            run = !m_halt && !m_fl;
            f   = m_flags;
`ifdef BRANCH_FLAG_BYPASS_EN
            if (flags_we) f = {alu_carry, alu_sign, alu_zero};
`endif
            tk = 0; jr = 0;
            if (rst_n && run && instr_valid) begin
                case (branch_op)
                    1: tk = 1;
                    2: tk = f[1];
                    3: tk = !f[1];
                    4: tk = f[0];
                    5: tk = !f[0];
                    6: tk = f[2];
                    7: tk = !f[2];
                    8: begin tk = 1; jr = 1; end
                    default: ;
                endcase
            end
            hop  = rst_n && run && instr_valid && branch_op == 4'd9;
            esel = tk ? (jr ? 2 : 1) : 0;
            chk("m_sel",   branch_control_out, esel);
            chk("m_flush", flush, m_fl);
            chk("m_stall", pc_stall, rst_n && (m_halt || hop));
            chk("m_flags", flags_q, m_flags);
            chk("m_cnt",   taken_cnt, m_cnt);
            if (!rst_n) begin
                m_flags = 0; m_fl = 0; m_halt = 0; m_cnt = 0;
            end else begin
                if (flags_we) m_flags = {alu_carry, alu_sign, alu_zero};
                if (m_halt) begin
                    if (resume) m_halt = 0;
                end else if (m_fl) begin
                    m_fl = 0;
                end else begin
                    if (tk) begin m_fl = 1; if (m_cnt < CMAX) m_cnt++; end
                    if (hop) m_halt = 1;
                end
            end
        end
    end

    initial begin
        drv(0, 0, 0, 0, 0, 0);
        // Reset with random inputs
        for (int i = 0; i < 2; i++) begin
            tick();
            drv($urandom_range(0, 1), 4'($urandom_range(0, 15)), $urandom_range(0, 1),
                3'($urandom_range(0, 7)), $urandom_range(0, 1), 0);
        end
        #1;
        chk("rst_sel", branch_control_out, 0);
        chk("rst_flush", flush, 0);
        chk("rst_stall", pc_stall, 0);
        chk("rst_flags", flags_q, 0);
        chk("rst_cnt", taken_cnt, 0);
        tick();
        drv(0, 0, 0, 0, 0, 0);
        tick();
        model_on = 1'b1;

        // Load zero=1, then BZ next cycle
        drv(0, 0, 1, 3'b001, 0, 1); tick();
        drv(1, 4, 0, 0, 0, 1); #1;
        chk("bz_sel", branch_control_out, 1);
        #0 tick();
        drv(1, 5, 0, 0, 0, 1); #1;
        chk("bz_flush", flush, 1);
        chk("bz_cnt", taken_cnt, 1);
        chk("bnz_in_flush_sel", branch_control_out, 0);
        tick();
        drv(0, 0, 0, 0, 0, 1); #1;
        chk("bnz_in_flush_cnt", taken_cnt, 1);
        chk("after_flush", flush, 0);

        // sign=1, then BMI together with flags_we sign=0
        drv(0, 0, 1, 3'b010, 0, 1); tick();
        drv(1, 2, 1, 3'b000, 0, 1); #1;
`ifdef BRANCH_FLAG_BYPASS_EN
        chk("bmi_hazard_sel", branch_control_out, 0);
`else
        chk("bmi_hazard_sel", branch_control_out, 1);
`endif
        tick(); drv(0, 0, 0, 0, 0, 1); tick();

        // JR then BR
        drv(1, 8, 0, 0, 0, 1); #1;
        chk("jr_sel", branch_control_out, 2);
        tick(); drv(0, 0, 0, 0, 0, 1); #1;
        chk("jr_flush", flush, 1);
        tick(); drv(1, 1, 0, 0, 0, 1); #1;
        chk("br_after_jr", branch_control_out, 1);
        tick(); drv(0, 0, 0, 0, 0, 1); tick();

        // HALT, BR ignored, flags still update, then resume
        drv(1, 9, 0, 0, 0, 1); #1;
        chk("halt_op_stall", pc_stall, 1);
        chk("halt_op_sel", branch_control_out, 0);
        tick();
        for (int i = 0; i < 5; i++) begin
            drv(1, 1, 1, 3'(i + 2), 0, 1); #1;
            chk("halt_stall", pc_stall, 1);
            chk("halt_sel", branch_control_out, 0);
            tick();
        end
        drv(1, 1, 0, 0, 1, 1); #1;
        chk("halt_flags", flags_q, 3'd6);
        chk("resume_stall", pc_stall, 1);
        tick(); drv(0, 0, 0, 0, 0, 1); #1;
        chk("resumed_stall", pc_stall, 0);
        tick();

        // Saturation
        for (int i = 0; i < 20; i++) begin
            drv(1, 1, 0, 0, 0, 1); tick();
            drv(0, 0, 0, 0, 0, 1); tick();
        end
        chk("sat_cnt", taken_cnt, CMAX);
        drv(1, 1, 0, 0, 0, 1); tick();
        drv(1, 1, 0, 0, 0, 0); #1;
        chk("flush_before_rst", flush, 1);
        tick(); drv(0, 0, 0, 0, 0, 1); #1;
        chk("rst_in_flush_cnt", taken_cnt, 0);
        chk("rst_in_flush_flush", flush, 0);
        tick();

        // Randomized run
        for (int i = 0; i < 3000; i++) begin
            drv($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), $urandom_range(0, 1),
                3'($urandom_range(0, 7)), $urandom_range(0, 4) == 0, $urandom_range(0, 49) != 0);
            tick();
        end
        model_on = 1'b0;
        #10;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/branch_ctrl_unit.md
Name: branch_ctrl_unit

Overview:
- Producer side of the 2-bit next-address select consumed by the PC next-address mux.
  - Select codes: 00 = pc_add, 01 = instr_addr, 10 = reg_addr.
- Holds the architectural flag register (zero, sign, carry), latched from ALU results.
- Evaluates branch conditions against the registered flags and drives the mux select.
- Sequences the one-cycle squash after a taken branch, plus halt/resume; keeps a taken-branch counter for debug.

Parameters:
- CNT_W, 16, width of the saturating taken-branch counter.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk
- instr_valid  in  1  decoded instruction present this cycle
- branch_op  in  4  0 none, 1 BR, 2 BMI, 3 BPL, 4 BZ, 5 BNZ, 6 BCY, 7 BNC, 8 JR, 9 HALT, 10-15 treated as none
- flags_we  in  1  ALU result valid; update flag register
- alu_zero  in  1  ALU zero result
- alu_sign  in  1  ALU sign result
- alu_carry  in  1  ALU carry result
- resume  in  1  leave HALT
- branch_control_out  out  2  select to next-address mux
- flush  out  1  squash the instruction currently in decode (registered)
- pc_stall  out  1  hold PC (HALT state)
- flags_q  out  3  {carry, sign, zero} registered flags
- taken_cnt  out  CNT_W  saturating count of taken branches/jumps

Behaviour:
- Reset (rst_n=0 at clk edge) values:
  - state = RUN, flags_q = 0, flush = 0, taken_cnt = 0.
  - branch_control_out = 00, pc_stall = 0.
  - Reset mid-FLUSH or mid-HALT returns to RUN in the same edge.
- States:
  - RUN
  - FLUSH: exactly one cycle
  - HALT
- Condition evaluation: in RUN with instr_valid=1, combinationally from flags_q, not from same-cycle alu_* inputs.
  - BR: taken, select 01.
  - BMI: taken if sign=1; BPL: taken if sign=0. Select 01.
  - BZ: taken if zero=1; BNZ: taken if zero=0. Select 01.
  - BCY: taken if carry=1; BNC: taken if carry=0. Select 01.
  - JR: taken, select 10.
  - Not taken, or op none: select 00.
- branch_control_out is combinational (zero latency) in the decision cycle; the PC captures the selected address on the same edge.
- Taken branch or jump:
  - Next state = FLUSH; flush = 1 for the following cycle.
  - taken_cnt increments, saturating at all-ones.
- FLUSH:
  - branch_control_out = 00.
  - branch_op ignored (squashed instruction); HALT ignored too.
  - flag updates still honoured.
  - Returns to RUN unconditionally.
- HALT op in RUN with instr_valid=1:
  - branch_control_out = 00; next state = HALT.
  - pc_stall = 1 combinationally in the HALT op cycle and throughout the HALT state.
- HALT:
  - branch_control_out = 00; branch_op ignored.
  - resume=1 → RUN next edge; pc_stall deasserts in the cycle after.
- Flag register: flags_we=1 loads {alu_carry, alu_sign, alu_zero} at the edge, in any state including HALT.
- Same-cycle flags_we and conditional branch: the branch uses the old flags_q (base build).
- instr_valid=0: select 00, no state change apart from flag updates.

Optional Feature:
- Macro: BRANCH_FLAG_BYPASS_EN.
- Defined: condition evaluation uses the incoming alu_* values when flags_we=1 in the same cycle, else flags_q. Removes the one-instruction compare→branch hazard. Register update timing is unchanged.
- Undefined: evaluation uses flags_q only, as above.

Test Plan:
- Reset: hold rst_n=0 two cycles with random inputs → branch_control_out=00, flush=0, pc_stall=0, flags_q=000, taken_cnt=0.
- flags_we with zero=1, next cycle BZ → select 01, flush=1 next cycle, taken_cnt=1.
  - A BNZ in the FLUSH cycle → select 00, taken_cnt stays 1.
- flags_we with sign=0 and BMI in the same cycle → base build: select 01 if the old sign was 1, otherwise 00. With BRANCH_FLAG_BYPASS_EN: 00 regardless of old sign.
- JR → select 10, one flush cycle, return to RUN; BR in the following RUN cycle → 01.
- HALT → pc_stall=1, select 00 for 5 cycles while driving BR; flags_we still updates flags_q; resume=1 → RUN, pc_stall=0 next cycle.
- CNT_W=4 back-to-back taken BR (each followed by its flush cycle) ×20 → taken_cnt saturates at 15.
  - Assert rst_n=0 during a FLUSH cycle → counter 0, flush=0 after the edge.
